// File: rtl/exe_alu_mdu_pkg.sv
// exe_alu_mdu_pkg: ALU control encodings and divider FSM states shared by the E-stage ALU/MDU
package exe_alu_mdu_pkg;
  localparam logic [4:0] AND_CONTROL   = 5'd0;
  localparam logic [4:0] OR_CONTROL    = 5'd1;
  localparam logic [4:0] ADD_CONTROL   = 5'd2;
  localparam logic [4:0] SUB_CONTROL   = 5'd3;
  localparam logic [4:0] SLT_CONTROL   = 5'd4;
  localparam logic [4:0] XOR_CONTROL   = 5'd5;
  localparam logic [4:0] NOR_CONTROL   = 5'd6;
  localparam logic [4:0] SLL_CONTROL   = 5'd7;
  localparam logic [4:0] SRL_CONTROL   = 5'd8;
  localparam logic [4:0] SRA_CONTROL   = 5'd9;
  localparam logic [4:0] SLLV_CONTROL  = 5'd10;
  localparam logic [4:0] SRLV_CONTROL  = 5'd11;
  localparam logic [4:0] SRAV_CONTROL  = 5'd12;
  localparam logic [4:0] MULT_CONTROL  = 5'd13;
  localparam logic [4:0] MULTU_CONTROL = 5'd14;
  localparam logic [4:0] DIV_CONTROL   = 5'd15;
  localparam logic [4:0] DIVU_CONTROL  = 5'd16;
  localparam logic [4:0] MTHI_CONTROL  = 5'd17;
  localparam logic [4:0] MTLO_CONTROL  = 5'd18;
  localparam logic [4:0] MFHI_CONTROL  = 5'd19;
  localparam logic [4:0] MFLO_CONTROL  = 5'd20;
  typedef enum logic [1:0] {DIV_IDLE = 2'd0, DIV_BUSY = 2'd1, DIV_DONE = 2'd2} div_state_e;
  function automatic logic is_div(input logic [4:0] op);
    return op == DIV_CONTROL || op == DIVU_CONTROL;
  endfunction
endpackage

// File: rtl/exe_alu_mdu_div_radix2.sv
// div_radix2: unsigned restoring divider, one quotient bit per cycle, start/abort/done handshake
module div_radix2 #(
  parameter int N = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic        done_o,
  output logic [31:0] quo_o,
  output logic [31:0] rem_o
);
  localparam int CW = $clog2(N);
  logic        busy_q, ge;
  logic [CW-1:0] cnt_q;
  logic [31:0] rem_q, quo_q, dvs_q;
  logic [32:0] tmp, sub;
  assign tmp    = {rem_q, quo_q[31]};
  assign sub    = tmp - {1'b0, dvs_q};
  // explicit compare: a zero divisor must always "fit" so the remainder shifts in the dividend
  assign ge     = tmp >= {1'b0, dvs_q};
  assign done_o = busy_q & (cnt_q == CW'(N - 1));
  assign quo_o  = quo_q;
  assign rem_o  = rem_q;
  always_ff @(posedge clk) begin
    if (rst | abort_i) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= dividend_i;
      dvs_q  <= divisor_i;
    end else if (busy_q) begin
      busy_q <= ~done_o;
      cnt_q  <= cnt_q + 1'b1;
      rem_q  <= ge ? sub[31:0] : tmp[31:0];
      quo_q  <= {quo_q[30:0], ge};
    end
  end
endmodule

// File: rtl/exe_alu_mdu.sv
// exe_alu_mdu: E-stage ALU with HI/LO registers; `MDU_DIV_EN selects the iterative
// stalling divider, otherwise DIV/DIVU retire in one cycle writing HI=LO=0.
module exe_alu_mdu
  import exe_alu_mdu_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  aluctrl,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [4:0]  sa,
  input  logic        valid_e,
  input  logic        flush_e,
  output logic [31:0] result,
  output logic        overflow,
  output logic        stall_e,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);
  logic [31:0] hi_q, hi_d, lo_q, lo_d, sum, dif, div_hi, div_lo;
  logic [63:0] mul_s, mul_u;
  logic        wr, div_we;
  assign sum   = a + b;
  assign dif   = a - b;
  assign mul_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign mul_u = {32'b0, a} * {32'b0, b};
  assign wr    = valid_e & ~stall_e & ~flush_e;
  assign hi_o  = hi_q;
  assign lo_o  = lo_q;
`ifdef MDU_DIV_EN
  div_state_e  state_q, state_d;
  logic        div_start, div_done, sgn, qneg_q, rneg_q;
  logic [31:0] quo, rem;
  assign sgn       = aluctrl == DIV_CONTROL;
  assign div_start = (state_q == DIV_IDLE) & valid_e & ~flush_e & is_div(aluctrl);
  assign stall_e   = div_start | (state_q == DIV_BUSY);
  assign div_we    = (state_q == DIV_DONE) & ~flush_e;
  assign div_hi    = rneg_q ? -rem : rem;
  assign div_lo    = qneg_q ? -quo : quo;
  always_comb begin
    state_d = (state_q == DIV_IDLE) ? (div_start ? DIV_BUSY : DIV_IDLE) :
              (state_q == DIV_BUSY) ? (flush_e ? DIV_IDLE : (div_done ? DIV_DONE : DIV_BUSY)) :
              DIV_IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DIV_IDLE;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (div_start) begin
        qneg_q <= sgn & (a[31] ^ b[31]);
        rneg_q <= sgn & a[31];
      end
    end
  end
  div_radix2 #(.N(DIV_CYCLES)) u_div (
    .clk        (clk),
    .rst        (rst),
    .start_i    (div_start),
    .abort_i    (flush_e & (state_q != DIV_IDLE)),
    .dividend_i ((sgn & a[31]) ? -a : a),
    .divisor_i  ((sgn & b[31]) ? -b : b),
    .done_o     (div_done),
    .quo_o      (quo),
    .rem_o      (rem)
  );
`else
  assign stall_e = 1'b0;
  assign div_we  = wr & is_div(aluctrl);
  assign div_hi  = 32'b0;
  assign div_lo  = 32'b0;
`endif
  always_comb begin
    result   = 32'b0;
    overflow = 1'b0;
    case (aluctrl)
      AND_CONTROL:  result = a & b;
      OR_CONTROL:   result = a | b;
      XOR_CONTROL:  result = a ^ b;
      NOR_CONTROL:  result = ~(a | b);
      ADD_CONTROL: begin
        result   = sum;
        overflow = (a[31] == b[31]) & (sum[31] != a[31]);
      end
      SUB_CONTROL: begin
        result   = dif;
        overflow = (a[31] != b[31]) & (dif[31] != a[31]);
      end
      SLT_CONTROL:  result = {31'b0, $signed(a) < $signed(b)};
      SLL_CONTROL:  result = b << sa;
      SRL_CONTROL:  result = b >> sa;
      SRA_CONTROL:  result = $signed(b) >>> sa;
      SLLV_CONTROL: result = b << a[4:0];
      SRLV_CONTROL: result = b >> a[4:0];
      SRAV_CONTROL: result = $signed(b) >>> a[4:0];
      MFHI_CONTROL: result = hi_q;
      MFLO_CONTROL: result = lo_q;
      default: ;
    endcase
  end
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (wr) begin
      case (aluctrl)
        MULT_CONTROL:  {hi_d, lo_d} = mul_s;
        MULTU_CONTROL: {hi_d, lo_d} = mul_u;
        MTHI_CONTROL:  hi_d = a;
        MTLO_CONTROL:  lo_d = a;
        default: ;
      endcase
    end
    if (div_we) {hi_d, lo_d} = {div_hi, div_lo};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= 32'b0;
      lo_q <= 32'b0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end
endmodule

// File: tb/tb_exe_alu_mdu.sv
// tb_exe_alu_mdu: directed vectors with a cycle-stamped expectation scoreboard
module tb_exe_alu_mdu;
  import exe_alu_mdu_pkg::*;
  localparam int S_RES = 0, S_OV = 1, S_HI = 2, S_LO = 3, S_ST = 4;
  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
    int          due;
  } exp_t;
  logic        clk, rst, valid_e, flush_e, overflow, stall_e;
  logic [4:0]  aluctrl, sa;
  logic [31:0] a, b, result, hi_o, lo_o;
  int          cyc = 0, n_chk = 0, n_err = 0;
  exp_t        q[$];

  exe_alu_mdu dut (
    .clk(clk), .rst(rst), .aluctrl(aluctrl), .a(a), .b(b), .sa(sa),
    .valid_e(valid_e), .flush_e(flush_e), .result(result), .overflow(overflow),
    .stall_e(stall_e), .hi_o(hi_o), .lo_o(lo_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    logic [31:0] act;
    for (int i = 0; i < q.size(); ) begin
      if (q[i].due == cyc) begin
        act = q[i].sel == S_RES ? result :
              q[i].sel == S_OV  ? {31'b0, overflow} :
              q[i].sel == S_HI  ? hi_o :
              q[i].sel == S_LO  ? lo_o : {31'b0, stall_e};
        n_chk++;
        if (act !== q[i].exp) begin
          n_err++;
          $display("FAIL %s @cycle %0d actual=%h required=%h", q[i].name, cyc, act, q[i].exp);
        end
        q.delete(i);
      end else i++;
    end
  end

  task automatic chk(input string n, input int sel, input logic [31:0] v, input int d = 0);
    q.push_back('{name: n, sel: sel, exp: v, due: cyc + d});
  endtask

  task automatic drv(input logic [4:0] c, input logic [31:0] aa, input logic [31:0] bb,
                     input logic [4:0] s = 5'd0, input logic v = 1'b1, input logic f = 1'b0);
    @(posedge clk);
    #1;
    aluctrl = c; a = aa; b = bb; sa = s; valid_e = v; flush_e = f;
  endtask

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; aluctrl = AND_CONTROL; a = 0; b = 0; sa = 0; valid_e = 0; flush_e = 0;
    hold(2);
    chk("rst_result", S_RES, 0); chk("rst_ov", S_OV, 0); chk("rst_stall", S_ST, 0);
    chk("rst_hi", S_HI, 0); chk("rst_lo", S_LO, 0);
    hold(1);
    rst = 1'b0;
    drv(ADD_CONTROL, 32'h7FFFFFFF, 32'h1);
    chk("add_res", S_RES, 32'h80000000); chk("add_ov", S_OV, 1);
    drv(ADD_CONTROL, 32'h80000000, 32'hFFFFFFFF);
    chk("add_neg_res", S_RES, 32'h7FFFFFFF); chk("add_neg_ov", S_OV, 1);
    drv(SUB_CONTROL, 32'd5, 32'd7);
    chk("sub_res", S_RES, 32'hFFFFFFFE); chk("sub_ov", S_OV, 0);
    drv(SUB_CONTROL, 32'h80000000, 32'h1);
    chk("sub_min_res", S_RES, 32'h7FFFFFFF); chk("sub_min_ov", S_OV, 1);
    drv(AND_CONTROL, 32'hF0F000FF, 32'h0FF00F0F); chk("and", S_RES, 32'h00F0000F);
    drv(OR_CONTROL,  32'hF0F000FF, 32'h0FF00F0F); chk("or",  S_RES, 32'hFFF00FFF);
    drv(XOR_CONTROL, 32'hF0F000FF, 32'h0FF00F0F); chk("xor", S_RES, 32'hFF000FF0);
    drv(NOR_CONTROL, 32'hF0F000FF, 32'h0FF00F0F); chk("nor", S_RES, 32'h000FF000); chk("nor_ov", S_OV, 0);
    drv(SLT_CONTROL, 32'hFFFFFFFF, 32'h1); chk("slt_lt", S_RES, 1);
    drv(SLT_CONTROL, 32'h1, 32'hFFFFFFFF); chk("slt_ge", S_RES, 0);
    drv(SLL_CONTROL, 32'h0, 32'h1, 5'd31); chk("sll", S_RES, 32'h80000000);
    drv(SRL_CONTROL, 32'h0, 32'h80000000, 5'd4); chk("srl", S_RES, 32'h08000000);
    drv(SRA_CONTROL, 32'h0, 32'h80000000, 5'd4); chk("sra", S_RES, 32'hF8000000);
    drv(SLLV_CONTROL, 32'd33, 32'h1); chk("sllv", S_RES, 32'h2);
    drv(SRLV_CONTROL, 32'd4, 32'hF0); chk("srlv", S_RES, 32'hF);
    drv(SRAV_CONTROL, 32'd36, 32'h80000000); chk("srav", S_RES, 32'hF8000000);
    drv(MULT_CONTROL, 32'hFFFFFFFE, 32'd3);
    chk("mult_hi", S_HI, 32'hFFFFFFFF, 1); chk("mult_lo", S_LO, 32'hFFFFFFFA, 1);
    drv(MFHI_CONTROL, 0, 0); chk("mfhi", S_RES, 32'hFFFFFFFF);
    drv(MFLO_CONTROL, 0, 0); chk("mflo", S_RES, 32'hFFFFFFFA);
    drv(MULTU_CONTROL, 32'hFFFFFFFE, 32'd3);
    chk("multu_hi", S_HI, 32'h2, 1); chk("multu_lo", S_LO, 32'hFFFFFFFA, 1);
    drv(MTHI_CONTROL, 32'h12345678, 0); chk("mthi", S_HI, 32'h12345678, 1);
    drv(MTLO_CONTROL, 32'h9ABCDEF0, 0); chk("mtlo", S_LO, 32'h9ABCDEF0, 1);
    drv(MULT_CONTROL, 32'd5, 32'd5, 5'd0, 1'b1, 1'b1);
    chk("flush_mult_hi", S_HI, 32'h12345678, 1); chk("flush_mult_lo", S_LO, 32'h9ABCDEF0, 1);
    drv(MULT_CONTROL, 32'd5, 32'd5, 5'd0, 1'b0);
    chk("bubble_mult_hi", S_HI, 32'h12345678, 1);
    drv(5'd31, 32'hFFFFFFFF, 32'hFFFFFFFF);
    chk("unlisted_res", S_RES, 0); chk("unlisted_ov", S_OV, 0);
    chk("unlisted_hi", S_HI, 32'h12345678, 1); chk("unlisted_lo", S_LO, 32'h9ABCDEF0, 1);
`ifdef MDU_DIV_EN
    drv(DIV_CONTROL, 32'hFFFFFFF9, 32'd2);
    for (int k = 0; k <= 32; k++) chk("div_stall_hi", S_ST, 1, k);
    chk("div_stall_lo", S_ST, 0, 33); chk("div_busy_hi", S_HI, 32'h12345678, 20);
    chk("div_hi", S_HI, 32'hFFFFFFFF, 34); chk("div_lo", S_LO, 32'hFFFFFFFD, 34);
    hold(33);
    drv(AND_CONTROL, 0, 0, 5'd0, 1'b0);
    drv(DIV_CONTROL, 32'd7, 32'hFFFFFFFE);
    chk("div2_stall", S_ST, 0, 33);
    chk("div2_hi", S_HI, 32'h1, 34); chk("div2_lo", S_LO, 32'hFFFFFFFD, 34);
    hold(33);
    drv(AND_CONTROL, 0, 0, 5'd0, 1'b0);
    drv(DIVU_CONTROL, 32'd7, 32'd0);
    chk("divz_stall_end", S_ST, 1, 32); chk("divz_stall", S_ST, 0, 33);
    chk("divz_hi", S_HI, 32'h7, 34); chk("divz_lo", S_LO, 32'hFFFFFFFF, 34);
    hold(33);
    drv(AND_CONTROL, 0, 0, 5'd0, 1'b0);
    drv(DIV_CONTROL, 32'd100, 32'd7);
    hold(9);
    drv(DIV_CONTROL, 32'd100, 32'd7, 5'd0, 1'b1, 1'b1);
    chk("flush_stall_now", S_ST, 1); chk("flush_stall_next", S_ST, 0, 1);
    chk("flush_hi", S_HI, 32'h7, 2); chk("flush_lo", S_LO, 32'hFFFFFFFF, 2);
    drv(AND_CONTROL, 0, 0, 5'd0, 1'b0);
    hold(2);
    drv(DIV_CONTROL, 32'd100, 32'd7);
    hold(4);
    rst = 1'b1; valid_e = 1'b0;
    chk("rstbusy_stall", S_ST, 1); chk("rstbusy_hi_pre", S_HI, 32'h7);
    hold(1);
    rst = 1'b0;
    chk("rstbusy_hi", S_HI, 0); chk("rstbusy_lo", S_LO, 0); chk("rstbusy_stall_off", S_ST, 0);
`else
    drv(MTHI_CONTROL, 32'h55, 0); chk("nd_mthi", S_HI, 32'h55, 1);
    drv(MTLO_CONTROL, 32'h66, 0); chk("nd_mtlo", S_LO, 32'h66, 1);
    drv(DIVU_CONTROL, 32'd8, 32'd2);
    chk("nd_divu_stall", S_ST, 0); chk("nd_divu_hi", S_HI, 0, 1); chk("nd_divu_lo", S_LO, 0, 1);
    drv(MTHI_CONTROL, 32'h77, 0);
    drv(DIV_CONTROL, 32'd8, 32'd2);
    chk("nd_div_stall", S_ST, 0); chk("nd_div_hi", S_HI, 0, 1);
`endif
    drv(AND_CONTROL, 0, 0, 5'd0, 1'b0);
    hold(3);
    n_chk++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain actual=%0d required=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
